// File: rtl/state_dump_scanner.sv
// state_dump_scanner: snapshots register file and data memory, then streams
// them as tagged records (header, registers, memory, optional trailer) over a
// valid/ready port. Snapshots start on an explicit trigger or a periodic timer.
// Optional build macro DUMP_CHECKSUM_EN adds an XOR checksum trailer record.
module state_dump_scanner #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_MEM  = 32,
  parameter int MEM_AW   = 5,
  parameter int IDX_W    = 8,
  parameter int PERIOD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  output logic [REG_AW-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [7:0]        missed_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_REG  = 3'd2,
`ifdef DUMP_CHECKSUM_EN
    ST_MEM  = 3'd3,
    ST_TRL  = 3'd4
`else
    ST_MEM  = 3'd3
`endif
  } state_t;

  // Running checksum step: every loaded payload is folded in by XOR.
  function automatic logic [DATA_W-1:0] chk_fold(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction

  // Entry counter to record index, zero-extended or truncated.
  function automatic logic [IDX_W-1:0] to_idx(input logic [31:0] v);
    return IDX_W'(v);
  endfunction

  state_t              state_r, state_s;
  logic [31:0]         idx_r, idx_s;
  logic [IDX_W-1:0]    seq_r, seq_s;
  logic [DATA_W-1:0]   cyc_r;
  logic [7:0]          missed_r, missed_s;
  logic                valid_r, valid_s;
  logic [1:0]          kind_r, kind_s;
  logic [IDX_W-1:0]    index_r, index_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic                busy_r, busy_s;
  logic [REG_AW-1:0]   raddr_r, raddr_s;
  logic [MEM_AW-1:0]   maddr_r, maddr_s;
  logic                auto_trig_s;
  logic                req_s;
  logic                xfer_s;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   acc_r, acc_s;
`endif

  if (PERIOD > 0) begin : g_period
    logic [31:0] period_cnt_r;
    // Period counter runs 0..PERIOD-1 and flags the terminal count.
    always_ff @(posedge clk) begin
      if (reset) begin
        period_cnt_r <= 32'd0;
      end else if (period_cnt_r == 32'(PERIOD - 1)) begin
        period_cnt_r <= 32'd0;
      end else begin
        period_cnt_r <= period_cnt_r + 32'd1;
      end
    end
    assign auto_trig_s = (period_cnt_r == 32'(PERIOD - 1));
  end else begin : g_noperiod
    assign auto_trig_s = 1'b0;
  end

  assign req_s  = trigger | auto_trig_s;
  assign xfer_s = valid_r & out_ready;

  // Next-state, next-record and drop-counter logic of the scan FSM.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    seq_s    = seq_r;
    missed_s = missed_r;
    valid_s  = valid_r;
    kind_s   = kind_r;
    index_s  = index_r;
    data_s   = data_r;
    busy_s   = busy_r;
    raddr_s  = raddr_r;
    maddr_s  = maddr_r;
`ifdef DUMP_CHECKSUM_EN
    acc_s    = acc_r;
`endif
    // A request outside IDLE never restarts a snapshot; it is only counted.
    if (req_s && (state_r != ST_IDLE) && (missed_r != 8'hFF)) begin
      missed_s = missed_r + 8'd1;
    end else begin
      missed_s = missed_r;
    end
    case (state_r)
      ST_IDLE: begin
        raddr_s = '0;
        maddr_s = '0;
        if (req_s) begin
          state_s = ST_HDR;
          valid_s = 1'b1;
          busy_s  = 1'b1;
          kind_s  = 2'd0;
          index_s = seq_r;
          data_s  = cyc_r;
          seq_s   = seq_r + IDX_W'(1);
          idx_s   = 32'd0;
`ifdef DUMP_CHECKSUM_EN
          acc_s   = chk_fold('0, cyc_r);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          state_s = ST_REG;
          kind_s  = 2'd1;
          index_s = '0;
          data_s  = reg_rd_data;
          idx_s   = 32'd0;
          raddr_s = REG_AW'(1);
`ifdef DUMP_CHECKSUM_EN
          acc_s   = chk_fold(acc_r, reg_rd_data);
`endif
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_REG: begin
        if (xfer_s && (idx_r < 32'(NUM_REGS - 1))) begin
          index_s = to_idx(idx_r + 32'd1);
          data_s  = reg_rd_data;
          idx_s   = idx_r + 32'd1;
          raddr_s = REG_AW'(idx_r + 32'd2);
`ifdef DUMP_CHECKSUM_EN
          acc_s   = chk_fold(acc_r, reg_rd_data);
`endif
        end else if (xfer_s) begin
          state_s = ST_MEM;
          kind_s  = 2'd2;
          index_s = '0;
          data_s  = mem_rd_data;
          idx_s   = 32'd0;
          raddr_s = '0;
          maddr_s = MEM_AW'(1);
`ifdef DUMP_CHECKSUM_EN
          acc_s   = chk_fold(acc_r, mem_rd_data);
`endif
        end else begin
          state_s = ST_REG;
        end
      end
      ST_MEM: begin
        if (xfer_s && (idx_r < 32'(NUM_MEM - 1))) begin
          index_s = to_idx(idx_r + 32'd1);
          data_s  = mem_rd_data;
          idx_s   = idx_r + 32'd1;
          maddr_s = MEM_AW'(idx_r + 32'd2);
`ifdef DUMP_CHECKSUM_EN
          acc_s   = chk_fold(acc_r, mem_rd_data);
`endif
        end else if (xfer_s) begin
          maddr_s = '0;
          idx_s   = 32'd0;
`ifdef DUMP_CHECKSUM_EN
          state_s = ST_TRL;
          kind_s  = 2'd3;
          index_s = '0;
          data_s  = acc_r;
`else
          state_s = ST_IDLE;
          valid_s = 1'b0;
          busy_s  = 1'b0;
`endif
        end else begin
          state_s = ST_MEM;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_TRL: begin
        if (xfer_s) begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end else begin
          state_s = ST_TRL;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        raddr_s = '0;
        maddr_s = '0;
      end
    endcase
  end

  // State, output record, counters and read addresses; reset clears all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      idx_r    <= 32'd0;
      seq_r    <= '0;
      cyc_r    <= '0;
      missed_r <= 8'd0;
      valid_r  <= 1'b0;
      kind_r   <= 2'd0;
      index_r  <= '0;
      data_r   <= '0;
      busy_r   <= 1'b0;
      raddr_r  <= '0;
      maddr_r  <= '0;
`ifdef DUMP_CHECKSUM_EN
      acc_r    <= '0;
`endif
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      seq_r    <= seq_s;
      cyc_r    <= cyc_r + DATA_W'(1);
      missed_r <= missed_s;
      valid_r  <= valid_s;
      kind_r   <= kind_s;
      index_r  <= index_s;
      data_r   <= data_s;
      busy_r   <= busy_s;
      raddr_r  <= raddr_s;
      maddr_r  <= maddr_s;
`ifdef DUMP_CHECKSUM_EN
      acc_r    <= acc_s;
`endif
    end
  end

  assign out_valid   = valid_r;
  assign out_kind    = kind_r;
  assign out_index   = index_r;
  assign out_data    = data_r;
  assign busy        = busy_r;
  assign missed_cnt  = missed_r;
  assign reg_rd_addr = raddr_r;
  assign mem_rd_addr = maddr_r;

endmodule
